// File: rtl/mem_access_unit_if.sv
// Request/response handshake and Memory port bundle for mem_access_unit.
// slave = the unit itself, master = requester plus attached Memory.
interface mem_access_unit_if #(
   parameter int ADDR_BITS = 8,
   parameter int BITS      = 64
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_write;
   logic [1:0]             req_size;
   logic                   req_unsigned;
   logic [ADDR_BITS+2:0]   req_addr;
   logic [BITS-1:0]        req_wdata;
   logic                   resp_valid;
   logic [BITS-1:0]        resp_rdata;
   logic                   resp_error;
   logic [ADDR_BITS-1:0]   mem_address;
   logic [BITS-1:0]        mem_writeData;
   logic [BITS-1:0]        mem_readData;
   logic                   mem_writeEn;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_readData,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_address, mem_writeData, mem_writeEn
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output mem_readData,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_address, mem_writeData, mem_writeEn
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word/dword load-store unit in front of a single-port 64-bit word Memory.
// Sub-word stores are done as read-modify-write of the containing word.
//
// state | meaning
// IDLE  | ready for a request; latches request fields on acceptance
// READ  | Memory word addressed; captured at exit (load result or RMW merge)
// WRITE | mem_writeEn high for one cycle with the final word
// RESP  | resp_valid pulse; always returns to IDLE
module mem_access_unit #(
   parameter int ADDR_BITS = 8,
   parameter int BITS      = 64
) (
   input logic             clk,
   input logic             rst_n,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateType;

   stateType state, stateNext;

   logic            writeQ;
   logic            unsignedQ;
   logic [1:0]      sizeQ;
   logic [2:0]      offQ;
   logic [BITS-1:0] wdataQ;

   logic            reqMisaligned;
   logic [BITS-1:0] shiftedWord;
   logic [BITS-1:0] loadValue;
   logic [BITS-1:0] laneMask;
   logic [BITS-1:0] mergedWord;

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'b01:   return off[0];
         2'b10:   return |off[1:0];
         2'b11:   return |off;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [BITS-1:0] sizeMask(input logic [1:0] size);
      case (size)
         2'b00:   return {{(BITS-8){1'b0}}, 8'hFF};
         2'b01:   return {{(BITS-16){1'b0}}, 16'hFFFF};
         2'b10:   return {{(BITS-32){1'b0}}, 32'hFFFF_FFFF};
         default: return {BITS{1'b1}};
      endcase
   endfunction

   assign reqMisaligned = misaligned(bus.req_size, bus.req_addr[2:0]);

   assign bus.req_ready   = (state == IDLE) & rst_n;
   assign bus.resp_valid  = (state == RESP);
   assign bus.mem_writeEn = (state == WRITE);

   // Load path: bring the addressed lanes down to bit 0, then extend.
   assign shiftedWord = bus.mem_readData >> {offQ, 3'b000};

   always_comb begin
      loadValue = bus.mem_readData;
      case (sizeQ)
         2'b00:   loadValue = {{(BITS-8){~unsignedQ & shiftedWord[7]}}, shiftedWord[7:0]};
         2'b01:   loadValue = {{(BITS-16){~unsignedQ & shiftedWord[15]}}, shiftedWord[15:0]};
         2'b10:   loadValue = {{(BITS-32){~unsignedQ & shiftedWord[31]}}, shiftedWord[31:0]};
         default: loadValue = bus.mem_readData;
      endcase
   end

   // Store path: replace only the addressed lanes of the word just read.
   assign laneMask   = sizeMask(sizeQ) << {offQ, 3'b000};
   assign mergedWord = (bus.mem_readData & ~laneMask) | ((wdataQ << {offQ, 3'b000}) & laneMask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (reqMisaligned) begin
                  stateNext = RESP;
               end else if (bus.req_write && (bus.req_size == 2'b11)) begin
                  stateNext = WRITE;
               end else begin
                  stateNext = READ;
               end
            end
         end
         READ:    stateNext = writeQ ? WRITE : RESP;
         WRITE:   stateNext = RESP;
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         writeQ            <= 1'b0;
         unsignedQ         <= 1'b0;
         sizeQ             <= 2'b00;
         offQ              <= 3'b000;
         wdataQ            <= '0;
         bus.resp_rdata    <= '0;
         bus.resp_error    <= 1'b0;
         bus.mem_address   <= '0;
         bus.mem_writeData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  writeQ    <= bus.req_write;
                  unsignedQ <= bus.req_unsigned;
                  sizeQ     <= bus.req_size;
                  offQ      <= bus.req_addr[2:0];
                  wdataQ    <= bus.req_wdata;
                  if (reqMisaligned) begin
                     bus.resp_error <= 1'b1;
                     bus.resp_rdata <= '0;
                  end else begin
                     bus.mem_address <= bus.req_addr[ADDR_BITS+2:3];
                     if (bus.req_write && (bus.req_size == 2'b11)) begin
                        bus.mem_writeData <= bus.req_wdata;
                     end
                  end
               end
            end
            READ: begin
               if (writeQ) begin
                  bus.mem_writeData <= mergedWord;
               end else begin
                  bus.resp_rdata <= loadValue;
                  bus.resp_error <= 1'b0;
               end
            end
            WRITE: begin
               bus.resp_rdata <= '0;
               bus.resp_error <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/back-to-back sequences,
// and random traffic checked against a byte-addressed memory model.
module tb_mem_access_unit;

   localparam int ADDR_BITS = 8;
   localparam int DEPTH     = 1 << ADDR_BITS;
   localparam int NBYTES    = DEPTH * 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_BITS(ADDR_BITS), .BITS(64)) bus ();

   mem_access_unit #(.ADDR_BITS(ADDR_BITS), .BITS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Attached Memory: combinational read, posedge write.
   logic [63:0] mem [0:DEPTH-1];
   assign bus.mem_readData = mem[bus.mem_address];
   always @(posedge clk) if (bus.mem_writeEn) mem[bus.mem_address] <= bus.mem_writeData;

   // Reference model storage: flat byte array.
   logic [7:0] refMem [0:NBYTES-1];

   int nVec = 0;
   int nErr = 0;

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [10:0] a;
      logic [63:0] wd;
      logic [63:0] expRd;
      logic        expEr;
      int          expLat;
   } vecT;

   vecT vec [15];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model: access size in bytes straight from the byte array.
   task automatic modelAccess(input logic w, input logic [1:0] sz, input logic u,
                              input logic [10:0] a, input logic [63:0] wd,
                              output logic [63:0] rd, output logic er, output int lat);
      int n;
      logic [63:0] v;
      n  = 1 << sz;
      rd = '0;
      er = 1'b0;
      if ((int'(a) % n) != 0) begin
         er  = 1'b1;
         lat = 1;
         return;
      end
      if (w) begin
         for (int i = 0; i < n; i++) refMem[(int'(a) + i) % NBYTES] = wd[8*i +: 8];
         lat = (n == 8) ? 2 : 3;
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[(int'(a) + i) % NBYTES];
         if (!u && v[8*n-1]) for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
         rd  = v;
         lat = 2;
      end
   endtask

   task automatic doReq(input logic w, input logic [1:0] sz, input logic u,
                        input logic [10:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat,
                        output int wenCnt, output logic [7:0] wAddr);
      int guard;
      rd = '0; er = 1'b0; lat = -1; wenCnt = 0; wAddr = '0;
      @(negedge clk);
      bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         bus.req_valid = 1'b0;
         check("ready timeout", 64'(bus.req_ready), 64'd1);
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (bus.mem_writeEn) begin
            wenCnt++;
            wAddr = bus.mem_address;
         end
         if (bus.resp_valid) begin
            rd  = bus.resp_rdata;
            er  = bus.resp_error;
            lat = c;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) begin
         check("resp timeout", 64'(bus.resp_valid), 64'd1);
         return;
      end
      @(negedge clk);
      check("resp pulse width", 64'(bus.resp_valid), 64'd0);
      check("resp_rdata hold", bus.resp_rdata, rd);
   endtask

   task automatic runCheck(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [10:0] a, input logic [63:0] wd,
                           input logic [63:0] expRd, input logic expEr, input int expLat);
      logic [63:0] rd;
      logic        er;
      int          lat, wenCnt;
      logic [7:0]  wAddr;
      doReq(w, sz, u, a, wd, rd, er, lat, wenCnt, wAddr);
      check({tag, " rdata"}, rd, expRd);
      check({tag, " error"}, 64'(er), 64'(expEr));
      check({tag, " latency"}, 64'(lat), 64'(expLat));
      check({tag, " writeEn cycles"}, 64'(wenCnt), (w && !expEr) ? 64'd1 : 64'd0);
      if (w && !expEr) check({tag, " write address"}, 64'(wAddr), 64'(a[10:3]));
   endtask

   initial begin
      logic [63:0] val, mrd, saved, expA, expB;
      logic        mer;
      int          mlat;
      logic        w, u;
      logic [1:0]  sz;
      logic [10:0] a;
      logic [63:0] wd;
      logic [ 1:0] expReady [1:6];

      vec[0]  = '{1'b1, 2'd3, 1'b0, 11'h008, 64'h1122334455667788, 64'h0, 1'b0, 2};
      vec[1]  = '{1'b0, 2'd3, 1'b0, 11'h008, 64'h0, 64'h1122334455667788, 1'b0, 2};
      vec[2]  = '{1'b1, 2'd0, 1'b0, 11'h00D, 64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0, 3};
      vec[3]  = '{1'b0, 2'd3, 1'b0, 11'h008, 64'h0, 64'h1122AB4455667788, 1'b0, 2};
      vec[4]  = '{1'b0, 2'd0, 1'b0, 11'h00D, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 2};
      vec[5]  = '{1'b0, 2'd0, 1'b1, 11'h00D, 64'h0, 64'h00000000000000AB, 1'b0, 2};
      vec[6]  = '{1'b0, 2'd1, 1'b0, 11'h00C, 64'h0, 64'hFFFFFFFFFFFFAB44, 1'b0, 2};
      vec[7]  = '{1'b0, 2'd2, 1'b0, 11'h00A, 64'h0, 64'h0, 1'b1, 1};
      vec[8]  = '{1'b0, 2'd2, 1'b1, 11'h00C, 64'h0, 64'h000000001122AB44, 1'b0, 2};
      vec[9]  = '{1'b1, 2'd1, 1'b0, 11'h00E, 64'hCAFEF00D00001234, 64'h0, 1'b0, 3};
      vec[10] = '{1'b0, 2'd3, 1'b0, 11'h008, 64'h0, 64'h1234AB4455667788, 1'b0, 2};
      vec[11] = '{1'b1, 2'd3, 1'b0, 11'h00C, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1};
      vec[12] = '{1'b0, 2'd0, 1'b0, 11'h008, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2};
      vec[13] = '{1'b0, 2'd2, 1'b0, 11'h008, 64'h0, 64'h0000000055667788, 1'b0, 2};
      vec[14] = '{1'b0, 2'd1, 1'b0, 11'h00E, 64'h0, 64'h0000000000001234, 1'b0, 2};

      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      rst_n = 1'b0;
      for (int wi = 0; wi < DEPTH; wi++) begin
         val = {$urandom, $urandom};
         mem[wi] <= val;
         for (int b = 0; b < 8; b++) refMem[wi*8 + b] = val[8*b +: 8];
      end

      #12;
      check("reset req_ready", 64'(bus.req_ready), 64'd0);
      check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
      check("reset resp_error", 64'(bus.resp_error), 64'd0);
      check("reset resp_rdata", bus.resp_rdata, 64'd0);
      check("reset mem_address", 64'(bus.mem_address), 64'd0);
      check("reset mem_writeData", bus.mem_writeData, 64'd0);
      check("reset mem_writeEn", 64'(bus.mem_writeEn), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready after reset", 64'(bus.req_ready), 64'd1);

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         modelAccess(vec[i].w, vec[i].sz, vec[i].u, vec[i].a, vec[i].wd, mrd, mer, mlat);
         runCheck($sformatf("vec%0d", i), vec[i].w, vec[i].sz, vec[i].u, vec[i].a, vec[i].wd,
                  vec[i].expRd, vec[i].expEr, vec[i].expLat);
      end
      check("word1 after table", mem[1], 64'h1234AB4455667788);

      // Reset during the WRITE cycle of a half store to word 2
      @(negedge clk);
      saved = mem[2];
      bus.req_write = 1'b1; bus.req_size = 2'd1; bus.req_unsigned = 1'b0;
      bus.req_addr = 11'h012; bus.req_wdata = 64'hBEEF; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("abort writeEn before reset", 64'(bus.mem_writeEn), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort writeEn dropped", 64'(bus.mem_writeEn), 64'd0);
      check("abort req_ready", 64'(bus.req_ready), 64'd0);
      check("abort resp_valid", 64'(bus.resp_valid), 64'd0);
      check("abort mem_writeData", bus.mem_writeData, 64'd0);
      @(negedge clk);
      check("abort word unchanged", mem[2], saved);
      check("abort resp_valid held", 64'(bus.resp_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort ready after release", 64'(bus.req_ready), 64'd1);
      check("abort no late resp", 64'(bus.resp_valid), 64'd0);

      // Back-to-back loads with req_valid held high
      modelAccess(1'b0, 2'd3, 1'b0, 11'h008, 64'h0, expA, mer, mlat);
      modelAccess(1'b0, 2'd0, 1'b1, 11'h021, 64'h0, expB, mer, mlat);
      expReady[1] = 2'b00; expReady[2] = 2'b01; expReady[3] = 2'b10;
      expReady[4] = 2'b00; expReady[5] = 2'b01; expReady[6] = 2'b10;
      @(negedge clk);
      bus.req_write = 1'b0; bus.req_size = 2'd3; bus.req_unsigned = 1'b0;
      bus.req_addr = 11'h008; bus.req_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("b2b ready c%0d", c), 64'(bus.req_ready), 64'(expReady[c][1]));
         check($sformatf("b2b resp c%0d", c), 64'(bus.resp_valid), 64'(expReady[c][0]));
         if (c == 1) begin
            bus.req_size = 2'd0; bus.req_unsigned = 1'b1; bus.req_addr = 11'h021;
         end
         if (c == 2) check("b2b rdata A", bus.resp_rdata, expA);
         if (c == 4) bus.req_valid = 1'b0;
         if (c == 5) check("b2b rdata B", bus.resp_rdata, expB);
      end

      // Random traffic against the byte-array model
      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom_range(1));
         u  = 1'($urandom_range(1));
         sz = 2'($urandom_range(3));
         a  = 11'($urandom);
         if ($urandom_range(3) != 0) a = a & ~11'((1 << sz) - 1);
         wd = {$urandom, $urandom};
         modelAccess(w, sz, u, a, wd, mrd, mer, mlat);
         runCheck($sformatf("rnd%0d", i), w, sz, u, a, wd, mrd, mer, mlat);
      end

      @(negedge clk);
      for (int wi = 0; wi < DEPTH; wi++) begin
         for (int b = 0; b < 8; b++) val[8*b +: 8] = refMem[wi*8 + b];
         check($sformatf("final mem[%0d]", wi), mem[wi], val);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

endmodule
